// File: rtl/fxp_gen_pkg.sv
// rtl/fxp_gen_pkg.sv - shared constants, FSM state type and LFSR step for operand generators
//   LFSR_TAPS : Galois feedback mask for the 64-bit right-shifting LFSR
//   state_t   : operand bank fill FSM states
//   lfsr_step : one LFSR advance
package fxp_gen_pkg;

  localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [63:0] lfsr_step(input logic [63:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 64'h0);
  endfunction

endpackage

// File: rtl/fxp_lfsr64.sv
// rtl/fxp_lfsr64.sv - 64-bit Galois LFSR register with seed load, enable and zero-seed guard
//   clk, rst : clock, synchronous active-high reset (value <= SEED)
//   load     : load seed (seed of 0 is replaced by SEED); has priority over en
//   seed     : seed value
//   en       : advance one step
//   value    : current LFSR state
module fxp_lfsr64
  import fxp_gen_pkg::*;
#(
  parameter logic [63:0] SEED = 64'h0000_0000_0000_0065
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [63:0] seed,
  input  logic        en,
  output logic [63:0] value
);

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= SEED;
    end else if (load) begin
      // An all-zero state would lock the LFSR, so fall back to the default seed.
      value <= (seed == 64'h0) ? SEED : seed;
    end else if (en) begin
      value <= lfsr_step(value);
    end
  end

endmodule

// File: rtl/fxp_operand_bank_gen.sv
// rtl/fxp_operand_bank_gen.sv - pseudo-random fixed-point operand bank with multi-port reads
//   clk, rst  : clock, synchronous active-high reset
//   start     : begin a DEPTH-entry fill (IDLE only)
//   seed_load : load seed_in into the LFSR (IDLE only, wins over start)
//   seed_in   : new LFSR seed (0 selects SEED)
//   busy      : high while filling
//   done      : one-cycle pulse after the last write
//   wr_count  : entries written in the current or last fill
//   rd_idx    : NUM_RD packed read indices, port p at [p*AW +: AW]
//   rd_data   : NUM_RD packed read data, port p at [p*N +: N]; 0 for out-of-range index
//   Optional macro FXP_OPERAND_SIGNED_EN: negate entries whose LFSR bit 63 is set.
module fxp_operand_bank_gen
  import fxp_gen_pkg::*;
#(
  parameter int          DEPTH    = 200,
  parameter int          AW       = $clog2(DEPTH),
  parameter int          N        = 64,
  parameter int          Q        = 15,
  parameter int          INT_BITS = 8,
  parameter int          NUM_RD   = 3,
  parameter logic [63:0] SEED     = 64'h0000_0000_0000_0065
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 seed_load,
  input  logic [63:0]          seed_in,
  output logic                 busy,
  output logic                 done,
  output logic [AW-1:0]        wr_count,
  input  logic [NUM_RD*AW-1:0] rd_idx,
  output logic [NUM_RD*N-1:0]  rd_data
);

  localparam int VB = Q + INT_BITS;  // value bits taken from the LFSR

  state_t        state, state_nxt;
  logic [63:0]   lfsr_q, lfsr_nxt;
  logic          seed_take, fill_go, fill_en, last_write;
  logic [N-1:0]  mag, entry_val;
  logic [N-1:0]  bank [DEPTH];
  logic          unused_lfsr_bits;

  fxp_lfsr64 #(.SEED(SEED)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (seed_take),
    .seed  (seed_in),
    .en    (fill_en),
    .value (lfsr_q)
  );

  // The entry is built from the value the LFSR is about to take this cycle.
  assign lfsr_nxt         = lfsr_step(lfsr_q);
  assign unused_lfsr_bits = ^lfsr_nxt[63:VB];
  assign last_write       = (wr_count == AW'(DEPTH - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && !seed_load) state_nxt = FILL;
      FILL:    if (last_write) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == FILL);
    done      = (state == DONE);
    fill_en   = (state == FILL);
    seed_take = (state == IDLE) && seed_load;
    fill_go   = (state == IDLE) && start && !seed_load;
  end

  always_ff @(posedge clk) begin
    if (rst)          wr_count <= '0;
    else if (fill_go) wr_count <= '0;
    else if (fill_en) wr_count <= wr_count + AW'(1);
  end

  always_comb begin
    mag         = '0;
    mag[VB-1:0] = lfsr_nxt[VB-1:0];
`ifdef FXP_OPERAND_SIGNED_EN
    entry_val = lfsr_nxt[63] ? -mag : mag;
`else
    entry_val = mag;
`endif
  end

  // Bank contents survive reset; only the fill writes them.
  always_ff @(posedge clk) begin
    if (fill_en) bank[wr_count] <= entry_val;
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [AW-1:0] idx;
    assign idx = rd_idx[p*AW +: AW];
    assign rd_data[p*N +: N] = (32'(idx) < DEPTH) ? bank[idx] : '0;
  end

endmodule

// File: tb/tb_fxp_operand_bank_gen.sv
// tb/tb_fxp_operand_bank_gen.sv - self-checking bench for fxp_operand_bank_gen
module tb_fxp_operand_bank_gen;

  localparam int DEPTH  = 200;
  localparam int AW     = 8;
  localparam int N      = 64;
  localparam int NUM_RD = 3;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 start = 1'b0;
  logic                 seed_load = 1'b0;
  logic [63:0]          seed_in = 64'h0;
  logic                 busy, done;
  logic [AW-1:0]        wr_count;
  logic [NUM_RD*AW-1:0] rd_idx = '0;
  logic [NUM_RD*N-1:0]  rd_data;

  int checks = 0;
  int failures = 0;

  logic [63:0] model [DEPTH];

  fxp_operand_bank_gen dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .seed_load (seed_load),
    .seed_in   (seed_in),
    .busy      (busy),
    .done      (done),
    .wr_count  (wr_count),
    .rd_idx    (rd_idx),
    .rd_data   (rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          do_load;
    logic [63:0] seed;
    logic [63:0] e [3];   // unsigned magnitude of entries 0..2
    bit          n [3];   // LFSR bit 63 for entries 0..2
  } vec_t;

  vec_t vecs [5];

  function automatic logic [63:0] tb_step(input logic [63:0] s);
    return {1'b0, s[63:1]} ^ (s[0] ? 64'hD800_0000_0000_0000 : 64'h0);
  endfunction

  function automatic logic [63:0] signed_adj(input logic [63:0] v, input bit neg);
`ifdef FXP_OPERAND_SIGNED_EN
    return neg ? -v : v;
`else
    return neg ? v : v;
`endif
  endfunction

  function automatic logic [63:0] tb_entry(input logic [63:0] s);
    return signed_adj(s & 64'h0000_0000_007F_FFFF, s[63]);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; start = 1'b0; seed_load = 1'b0;
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic load_seed(input logic [63:0] s);
    @(negedge clk); seed_in = s; seed_load = 1'b1;
    @(negedge clk); seed_load = 1'b0;
  endtask

  // Called on the first negedge after start was sampled (cycle 1).
  task automatic run_fill(output int bc, output int dp, output int dc);
    bc = 0; dp = 0; dc = 0;
    for (int c = 1; c <= 400; c++) begin
      if (busy) bc++;
      if (done) begin dp++; if (dc == 0) dc = c; end
      if (dc != 0 && c >= dc + 2) break;
      @(negedge clk);
    end
  endtask

  task automatic rd(input int p, input int idx, output logic [63:0] d);
    rd_idx[p*AW +: AW] = idx[AW-1:0];
    #1;
    d = rd_data[p*N +: N];
  endtask

  task automatic count_bank_mismatch(output int mism, output int upper_bad);
    logic [63:0] d;
    mism = 0; upper_bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      rd(0, i, d);
      if (d !== model[i]) mism++;
`ifdef FXP_OPERAND_SIGNED_EN
      if (d[63:23] != 41'h0 && d[63:23] != {41{1'b1}}) upper_bad++;
`else
      if (d[63:23] != 41'h0) upper_bad++;
`endif
    end
  endtask

  initial begin
    logic [63:0] s, d, d0, d1, d2;
    int bc, dp, dc, mism, ub;

    vecs[0] = '{do_load: 1'b0, seed: 64'h0,
                e: '{64'h32, 64'h19, 64'h0C}, n: '{1'b1, 1'b0, 1'b1}};
    vecs[1] = '{do_load: 1'b1, seed: 64'h3,
                e: '{64'h1, 64'h0, 64'h0}, n: '{1'b1, 1'b1, 1'b0}};
    vecs[2] = '{do_load: 1'b1, seed: 64'h0,
                e: '{64'h32, 64'h19, 64'h0C}, n: '{1'b1, 1'b0, 1'b1}};
    vecs[3] = '{do_load: 1'b1, seed: 64'h0000_0000_0080_0000,
                e: '{64'h40_0000, 64'h20_0000, 64'h10_0000}, n: '{1'b0, 1'b0, 1'b0}};
    vecs[4] = '{do_load: 1'b1, seed: 64'h0000_0000_00FF_FFFE,
                e: '{64'h7F_FFFF, 64'h3F_FFFF, 64'h1F_FFFF}, n: '{1'b0, 1'b1, 1'b1}};

    s = 64'h65;
    for (int i = 0; i < DEPTH; i++) begin
      s = tb_step(s);
      model[i] = tb_entry(s);
    end

    // Reset state
    do_reset();
    check("reset_busy", {63'h0, busy}, 64'h0);
    check("reset_done", {63'h0, done}, 64'h0);
    check("reset_wr_count", {56'h0, wr_count}, 64'h0);

    // Full default fill
    pulse_start();
    run_fill(bc, dp, dc);
    check("fill_busy_cycles", 64'(bc), 64'd200);
    check("fill_done_pulses", 64'(dp), 64'd1);
    check("fill_done_cycle", 64'(dc), 64'd201);
    check("fill_wr_count", {56'h0, wr_count}, 64'd200);
    count_bank_mismatch(mism, ub);
    check("fill_bank_vs_model", 64'(mism), 64'd0);
    check("fill_upper_bits", 64'(ub), 64'd0);

    // Table-driven seed vectors
    for (int v = 0; v < 5; v++) begin
      do_reset();
      if (vecs[v].do_load) load_seed(vecs[v].seed);
      pulse_start();
      run_fill(bc, dp, dc);
      for (int k = 0; k < 3; k++) begin
        rd(0, k, d);
        check($sformatf("vec%0d_entry%0d", v, k), d, signed_adj(vecs[v].e[k], vecs[v].n[k]));
      end
    end

`ifdef FXP_OPERAND_SIGNED_EN
    do_reset();
    load_seed(64'h3);
    pulse_start();
    run_fill(bc, dp, dc);
    rd(0, 0, d);
    check("signed_seed3_entry0", d, 64'hFFFF_FFFF_FFFF_FFFF);
`endif

    // seed_load wins over start in the same IDLE cycle
    do_reset();
    @(negedge clk); seed_in = 64'h3; seed_load = 1'b1; start = 1'b1;
    @(negedge clk); seed_load = 1'b0; start = 1'b0;
    check("prio_no_fill", {63'h0, busy}, 64'h0);
    pulse_start();
    run_fill(bc, dp, dc);
    rd(0, 0, d);
    check("prio_entry0", d, signed_adj(64'h1, 1'b1));

    // start held through the fill and seed_load mid-fill are ignored
    do_reset();
    pulse_start();
    bc = 0; dp = 0; dc = 0;
    for (int c = 1; c <= 400; c++) begin
      if (busy) bc++;
      if (done) begin dp++; if (dc == 0) dc = c; end
      if (dc != 0 && c >= dc + 2) break;
      start = busy;
      seed_in = 64'h3;
      seed_load = (c == 50);
      @(negedge clk);
    end
    start = 1'b0; seed_load = 1'b0;
    check("noisy_done_pulses", 64'(dp), 64'd1);
    check("noisy_done_cycle", 64'(dc), 64'd201);
    count_bank_mismatch(mism, ub);
    check("noisy_bank_vs_model", 64'(mism), 64'd0);

    // reset mid-fill, then restart from SEED
    do_reset();
    pulse_start();
    for (int c = 1; c < 100; c++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("midrst_busy", {63'h0, busy}, 64'h0);
    check("midrst_wr_count", {56'h0, wr_count}, 64'h0);
    pulse_start();
    run_fill(bc, dp, dc);
    check("midrst_done_cycle", 64'(dc), 64'd201);
    rd(0, 0, d);
    check("midrst_entry0", d, signed_adj(64'h32, 1'b1));

    // Three simultaneous reads, one out of range
    rd_idx[0*AW +: AW] = 8'd0;
    rd_idx[1*AW +: AW] = 8'd199;
    rd_idx[2*AW +: AW] = 8'd250;
    #1;
    d0 = rd_data[0*N +: N];
    d1 = rd_data[1*N +: N];
    d2 = rd_data[2*N +: N];
    check("port0_idx0", d0, model[0]);
    check("port1_idx199", d1, model[199]);
    check("port2_idx250", d2, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
